// File: rtl/sprite_anim_src_pkg.sv
// Shared defaults and helpers for the multi-frame sprite pixel source.
package sprite_anim_src_pkg;

  localparam int CD_DEF    = 12;
  localparam int PW_DEF    = 2;
  localparam int S2X_SHIFT = 1;

  typedef logic [CD_DEF-1:0] rgb_t;

  // Frame index needs at least one bit even for a single-frame sprite.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_anim_src_if.sv
// Host-side write bus for the sprite bitmap store and the colour palette.
interface sprite_anim_src_if #(
  parameter int ADDR = 12,
  parameter int PW   = 2,
  parameter int CD   = 12
);
  logic            we;
  logic [ADDR-1:0] addr_w;
  logic [PW-1:0]   pixel_in;
  logic            pal_we;
  logic [PW-1:0]   pal_addr;
  logic [CD-1:0]   pal_din;

  modport master (output we, addr_w, pixel_in, pal_we, pal_addr, pal_din);
  modport slave  (input  we, addr_w, pixel_in, pal_we, pal_addr, pal_din);
endinterface

// File: rtl/sprite_anim_src_ram.sv
// Bitmap store: simple dual-port, synchronous write, registered read-first read.
module sprite_anim_src_ram #(
  parameter int AW = 12,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr_w,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] addr_r,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (we) r_mem[addr_w] <= din;
    r_dout <= r_mem[addr_r];
  end

  assign dout = r_dout;
endmodule

// File: rtl/sprite_anim_src.sv
// Animated palette sprite source: shadowed placement, flip/2x addressing,
// two-stage RAM + palette pipeline and frame-tick driven animation.
module sprite_anim_src
  import sprite_anim_src_pkg::*;
#(
  parameter int            CD        = CD_DEF,
  parameter int            PW        = PW_DEF,
  parameter int            H_SIZE    = 32,
  parameter int            V_SIZE    = 32,
  parameter int            NFRAME    = 4,
  parameter logic [CD-1:0] KEY_COLOR = '0,
  parameter bit            TRANSP0   = 1'b1,
  localparam int           FW        = clog2_min1(NFRAME),
  localparam int           HW        = $clog2(H_SIZE),
  localparam int           VW        = $clog2(V_SIZE),
  localparam int           ADDR      = FW + VW + HW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic [10:0]   x0,
  input  logic [10:0]   y0,
  input  logic          frame_tick,
  input  logic          anim_en,
  input  logic [3:0]    anim_rate,
  input  logic          frame_ld,
  input  logic [FW-1:0] frame_sel,
  input  logic          hflip,
  input  logic          vflip,
  input  logic          scale2x,
  sprite_anim_src_if.slave wr,
  output logic [CD-1:0] sprite_rgb,
  output logic          sprite_on,
  output logic [FW-1:0] cur_frame
);
  logic [10:0]     r_x0_s, r_y0_s;
  logic            r_hflip_s, r_vflip_s, r_scale_s;
  logic [FW-1:0]   r_cur_frame, w_cur_frame_nxt;
  logic [3:0]      r_tick_cnt, w_tick_cnt_nxt;
  logic [11:0]     w_xr, w_yr;
  logic [10:0]     w_x_ext, w_y_ext;
  logic            w_in_region;
  logic [HW-1:0]   w_cx, w_cx_f;
  logic [VW-1:0]   w_ry, w_ry_f;
  logic [ADDR-1:0] w_addr_r;
  logic [PW-1:0]   w_code;
  logic            w_opaque;
  logic            r_in_d, r_on;
  logic [CD-1:0]   r_rgb;
  logic [CD-1:0]   r_pal [2**PW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x0_s    <= '0;
      r_y0_s    <= '0;
      r_hflip_s <= 1'b0;
      r_vflip_s <= 1'b0;
      r_scale_s <= 1'b0;
    end else if (frame_tick) begin
      r_x0_s    <= x0;
      r_y0_s    <= y0;
      r_hflip_s <= hflip;
      r_vflip_s <= vflip;
      r_scale_s <= scale2x;
    end
  end

  // Zero-extended subtraction: bit 11 set means the scan is left/above the origin.
  assign w_xr    = {1'b0, x} - {1'b0, r_x0_s};
  assign w_yr    = {1'b0, y} - {1'b0, r_y0_s};
  assign w_x_ext = r_scale_s ? 11'(H_SIZE << S2X_SHIFT) : 11'(H_SIZE);
  assign w_y_ext = r_scale_s ? 11'(V_SIZE << S2X_SHIFT) : 11'(V_SIZE);
  assign w_in_region = ~w_xr[11] & (w_xr[10:0] < w_x_ext) &
                       ~w_yr[11] & (w_yr[10:0] < w_y_ext);

  assign w_cx     = r_scale_s ? w_xr[HW-1+S2X_SHIFT:S2X_SHIFT] : w_xr[HW-1:0];
  assign w_ry     = r_scale_s ? w_yr[VW-1+S2X_SHIFT:S2X_SHIFT] : w_yr[VW-1:0];
  assign w_cx_f   = r_hflip_s ? HW'(H_SIZE - 1) - w_cx : w_cx;
  assign w_ry_f   = r_vflip_s ? VW'(V_SIZE - 1) - w_ry : w_ry;
  assign w_addr_r = {r_cur_frame, w_ry_f, w_cx_f};

  sprite_anim_src_ram #(.AW(ADDR), .DW(PW)) u_ram (
    .clk    (clk),
    .we     (wr.we),
    .addr_w (wr.addr_w),
    .din    (wr.pixel_in),
    .addr_r (w_addr_r),
    .dout   (w_code)
  );

  // Palette contents survive reset; only the write port touches them.
  always_ff @(posedge clk) begin
    if (wr.pal_we) r_pal[wr.pal_addr] <= wr.pal_din;
  end

  assign w_opaque = r_in_d & ~(TRANSP0 & (w_code == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_d <= 1'b0;
      r_on   <= 1'b0;
      r_rgb  <= KEY_COLOR;
    end else begin
      r_in_d <= w_in_region;
      r_on   <= w_opaque;
      r_rgb  <= w_opaque ? r_pal[w_code] : KEY_COLOR;
    end
  end

  // Load beats auto-advance; explicit wrap keeps NFRAME=1 pinned at frame 0.
  always_comb begin
    w_cur_frame_nxt = r_cur_frame;
    w_tick_cnt_nxt  = r_tick_cnt;
    if (frame_tick) begin
      if (frame_ld) begin
        w_cur_frame_nxt = frame_sel & FW'(NFRAME - 1);
        w_tick_cnt_nxt  = '0;
      end else if (anim_en) begin
        if (r_tick_cnt == anim_rate) begin
          w_tick_cnt_nxt  = '0;
          w_cur_frame_nxt = (r_cur_frame == FW'(NFRAME - 1)) ? '0 : r_cur_frame + 1'b1;
        end else begin
          w_tick_cnt_nxt = r_tick_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_frame <= '0;
      r_tick_cnt  <= '0;
    end else begin
      r_cur_frame <= w_cur_frame_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
    end
  end

  assign sprite_rgb = r_rgb;
  assign sprite_on  = r_on;
  assign cur_frame  = r_cur_frame;
endmodule

// File: tb/tb_sprite_anim_src.sv
// Self-checking bench for sprite_anim_src: directed scans plus randomized traffic
// checked against a coordinate-level reference model.
module tb_sprite_anim_src;
  import sprite_anim_src_pkg::*;

  localparam int          FW   = 2;
  localparam int          ADDR = 12;
  localparam logic [11:0] KEY  = 12'h000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [10:0]   x = '0, y = '0, x0 = '0, y0 = '0;
  logic          frame_tick = 1'b0, anim_en = 1'b0, frame_ld = 1'b0;
  logic          hflip = 1'b0, vflip = 1'b0, scale2x = 1'b0;
  logic [3:0]    anim_rate = '0;
  logic [FW-1:0] frame_sel = '0;
  logic [11:0]   sprite_rgb;
  logic          sprite_on;
  logic [FW-1:0] cur_frame;

  sprite_anim_src_if #(.ADDR(ADDR), .PW(2), .CD(12)) bus ();

  sprite_anim_src dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .x0         (x0),
    .y0         (y0),
    .frame_tick (frame_tick),
    .anim_en    (anim_en),
    .anim_rate  (anim_rate),
    .frame_ld   (frame_ld),
    .frame_sel  (frame_sel),
    .hflip      (hflip),
    .vflip      (vflip),
    .scale2x    (scale2x),
    .wr         (bus),
    .sprite_rgb (sprite_rgb),
    .sprite_on  (sprite_on),
    .cur_frame  (cur_frame)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [1:0]  m_mem [4096];
  rgb_t        m_pal [4];
  int          m_x0s, m_y0s, m_frame, m_tcnt;
  bit          m_hf, m_vf, m_sc;
  bit          s1_in;
  logic [1:0]  s1_code;
  logic [11:0] exp_rgb;
  bit          exp_on;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic bit inside_spr(input int px, input int py);
    int s, xr, yr;
    s  = m_sc ? 2 : 1;
    xr = px - m_x0s;
    yr = py - m_y0s;
    return (xr >= 0) && (xr < 32 * s) && (yr >= 0) && (yr < 32 * s);
  endfunction

  function automatic int raddr(input int px, input int py);
    int s, cx, ry;
    s  = m_sc ? 2 : 1;
    cx = (px - m_x0s) / s;
    ry = (py - m_y0s) / s;
    if (m_hf) cx = 31 - cx;
    if (m_vf) ry = 31 - ry;
    return m_frame * 1024 + ry * 32 + cx;
  endfunction

  // One clock: compare outputs, advance the model, wait for the next falling edge.
  task automatic step();
    check_eq("rgb", 32'(sprite_rgb), 32'(exp_rgb));
    check_eq("on", 32'(sprite_on), 32'(exp_on));
    check_eq("frame", 32'(cur_frame), 32'(m_frame));
    exp_on  = s1_in && (s1_code != 2'd0);
    exp_rgb = exp_on ? m_pal[s1_code] : KEY;
    s1_in   = inside_spr(int'(x), int'(y));
    s1_code = s1_in ? m_mem[raddr(int'(x), int'(y))] : 2'd0;
    if (bus.we)     m_mem[bus.addr_w]  = bus.pixel_in;
    if (bus.pal_we) m_pal[bus.pal_addr] = bus.pal_din;
    if (frame_tick) begin
      m_x0s = int'(x0);
      m_y0s = int'(y0);
      m_hf  = hflip;
      m_vf  = vflip;
      m_sc  = scale2x;
      if (frame_ld) begin
        m_frame = int'(frame_sel) % 4;
        m_tcnt  = 0;
      end else if (anim_en) begin
        if (m_tcnt == int'(anim_rate)) begin
          m_tcnt  = 0;
          m_frame = (m_frame + 1) % 4;
        end else begin
          m_tcnt = (m_tcnt + 1) % 16;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic probe(input string tag, input int px, input int py, input logic [11:0] want);
    x = 11'(px);
    y = 11'(py);
    step();
    step();
    check_eq(tag, 32'(sprite_rgb), 32'(want));
  endtask

  task automatic scan_row(input int py, input int xs, input int xe);
    y = 11'(py);
    for (int i = xs; i <= xe; i++) begin
      x = 11'(i);
      step();
    end
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int anim_tbl [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int after_ld [3]  = '{2, 2, 3};
    logic [11:0] pal_init [4] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F};

    bus.we = 1'b0; bus.addr_w = '0; bus.pixel_in = '0;
    bus.pal_we = 1'b0; bus.pal_addr = '0; bus.pal_din = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_rgb", 32'(sprite_rgb), 32'(KEY));
    check_eq("rst_on", 32'(sprite_on), 32'd0);
    check_eq("rst_frame", 32'(cur_frame), 32'd0);
    m_x0s = 0; m_y0s = 0; m_hf = 0; m_vf = 0; m_sc = 0; m_frame = 0; m_tcnt = 0;
    s1_in = 0; s1_code = 0; exp_rgb = KEY; exp_on = 0;
    reset = 1'b0;

    // Fill palette and bitmap while the scan sits far outside the sprite
    x = 11'd2000; y = 11'd2000;
    for (int i = 0; i < 4; i++) begin
      bus.pal_we = 1'b1; bus.pal_addr = 2'(i); bus.pal_din = pal_init[i];
      step();
    end
    bus.pal_we = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      bus.we = 1'b1; bus.addr_w = 12'(i);
      bus.pixel_in = (i < 1024) ? 2'(i % 32) : 2'($urandom);
      step();
    end
    bus.we = 1'b0;
    $display("[tb] load: palette and 4 frames written");

    x0 = 11'd100; y0 = 11'd100;
    tick();
    scan_row(100, 98, 133);
    probe("t1_code0", 100, 100, KEY);
    probe("t1_col1", 101, 100, 12'hF00);
    probe("t1_col2", 102, 100, 12'h0F0);
    probe("t1_col3", 103, 100, 12'h00F);
    probe("t1_left", 99, 100, KEY);
    probe("t1_right", 132, 100, KEY);
    $display("[tb] scan y=100 x=98..133 at origin (100,100)");

    hflip = 1'b1; vflip = 1'b1;
    probe("t2_shadowed", 101, 100, 12'hF00);
    tick();
    probe("t2_flip_31_31", 100, 100, 12'h00F);
    probe("t2_flip_30_31", 101, 100, 12'h0F0);
    scan_row(131, 98, 133);
    $display("[tb] h/v flip applied on frame_tick");

    hflip = 1'b0; vflip = 1'b0; scale2x = 1'b1; x0 = 11'd0; y0 = 11'd0;
    tick();
    scan_row(5, 0, 65);
    probe("t3_x2", 2, 0, 12'hF00);
    probe("t3_x3", 3, 0, 12'hF00);
    probe("t3_x63", 63, 0, 12'h00F);
    probe("t3_x64", 64, 0, KEY);
    probe("t3_x1", 1, 0, KEY);
    $display("[tb] scale2x scan x=0..65");

    scale2x = 1'b0; x0 = 11'd5; y0 = 11'd1000;
    tick();
    probe("t5_neg_xr", 2, 1023, KEY);
    probe("t5_y1023", 6, 1023, 12'hF00);
    bus.pal_we = 1'b1; bus.pal_addr = 2'd1; bus.pal_din = 12'hABC;
    step();
    check_eq("t5_pal_old", 32'(sprite_rgb), 32'h00000F00);
    bus.pal_we = 1'b0;
    step();
    check_eq("t5_pal_new", 32'(sprite_rgb), 32'h00000ABC);
    bus.pal_we = 1'b1; bus.pal_din = 12'hF00;
    step();
    bus.pal_we = 1'b0;
    $display("[tb] negative offset, far-edge and palette write collision");

    x0 = 11'd100; y0 = 11'd100; anim_rate = 4'd2; anim_en = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      check_eq("t4_anim", 32'(cur_frame), 32'(anim_tbl[t]));
      x = 11'(100 + t); y = 11'(100 + t);
      repeat (3) step();
    end
    tick();
    tick();
    frame_ld = 1'b1; frame_sel = 2'd2;
    tick();
    frame_ld = 1'b0;
    check_eq("t4_ld_wins", 32'(cur_frame), 32'd2);
    for (int t = 0; t < 3; t++) begin
      tick();
      check_eq("t4_after_ld", 32'(cur_frame), 32'(after_ld[t]));
    end
    $display("[tb] animation: rate 2 over 12 ticks, then load during due advance");

    anim_rate = 4'd1;
    for (int c = 0; c < 2500; c++) begin
      x = 11'(95 + $urandom_range(0, 80));
      y = 11'(95 + $urandom_range(0, 80));
      hflip = 1'($urandom); vflip = 1'($urandom); scale2x = 1'($urandom);
      if ($urandom_range(0, 63) == 0) x0 = 11'($urandom_range(90, 110));
      if ($urandom_range(0, 63) == 0) y0 = 11'($urandom_range(90, 110));
      frame_tick = ($urandom_range(0, 31) == 0);
      frame_ld   = frame_tick && ($urandom_range(0, 3) == 0);
      frame_sel  = 2'($urandom);
      anim_en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.we = 1'b1;
        if (inside_spr(int'(x), int'(y)) && $urandom_range(0, 1) == 1)
          bus.addr_w = 12'(raddr(int'(x), int'(y)));
        else
          bus.addr_w = 12'($urandom);
        bus.pixel_in = 2'($urandom);
      end else begin
        bus.we = 1'b0;
      end
      bus.pal_we   = ($urandom_range(0, 15) == 0);
      bus.pal_addr = 2'($urandom);
      bus.pal_din  = 12'($urandom);
      step();
    end
    frame_tick = 1'b0; frame_ld = 1'b0; bus.we = 1'b0; bus.pal_we = 1'b0;
    repeat (2) step();
    $display("[tb] randomized traffic: 2500 cycles");

    x0 = 11'd100; y0 = 11'd100; hflip = 1'b0; vflip = 1'b0; scale2x = 1'b0;
    tick();
    scan_row(102, 96, 110);
    x = 11'd105;
    #2 reset = 1'b1;
    #1;
    check_eq("t6_async_rgb", 32'(sprite_rgb), 32'(KEY));
    check_eq("t6_async_on", 32'(sprite_on), 32'd0);
    check_eq("t6_async_frame", 32'(cur_frame), 32'd0);
    m_x0s = 0; m_y0s = 0; m_hf = 0; m_vf = 0; m_sc = 0; m_frame = 0; m_tcnt = 0;
    s1_in = 0; s1_code = 0; exp_rgb = KEY; exp_on = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick();
    for (int r = 100; r < 104; r++) scan_row(r, 96, 135);
    $display("[tb] mid-scan reset and post-reset rescan of stored contents");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
